// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem loader.
//   state_e     : loader FSM state encoding
//   HDR_BYTES   : bytes in the frame header (word count N)
//   TRL_BYTES   : bytes in the frame trailer (32-bit payload sum)
//   BYTE_IDX_W  : width of the byte-within-word counter
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_TRL,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int HDR_BYTES  = 4;
   localparam int TRL_BYTES  = 4;
   localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word packer: shifts stream bytes in little-endian order and flags
// the cycle in which the 4th byte of a word arrives.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clr_i         : restart at byte 0 (load start)
//   byte_en_i     : byte_i is being accepted this cycle
//   byte_i        : stream byte
//   word_valid_o  : combinational, 4th byte accepted this cycle
//   word_o        : assembled word {b3,b2,b1,b0}, valid with word_valid_o
module imem_loader_pack
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(HDR_BYTES - 1);

   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic [23:0]           sh_q, sh_d;

   always_comb begin
      idx_d = idx_q;
      sh_d  = sh_q;
      if (clr_i) begin
         idx_d = '0;
         sh_d  = '0;
      end else if (byte_en_i) begin
         // counter wraps 3 -> 0 so the next word starts fresh
         idx_d = idx_q + 1'b1;
         sh_d  = {byte_i, sh_q[23:8]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= '0;
         sh_q  <= '0;
      end else begin
         idx_q <= idx_d;
         sh_q  <= sh_d;
      end
   end

   assign word_valid_o = byte_en_i && !clr_i && (idx_q == LAST_IDX);
   assign word_o       = {byte_i, sh_q};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed image (header N, N payload
// words, trailer sum) from a byte stream and writes it into imem while the
// core is held in reset.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start_i        : pulse, begin a load (ignored mid-frame)
//   byte_i/byte_valid_i/byte_ready_o : stream handshake
//   we_o/waddr_o/wdata_o : imem write port (one strobe per word)
//   cpu_hold_o     : core reset request
//   busy_o/done_o/err_o : load status
//   words_o        : words written by current/last load
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// HDR     | receiving 4-byte word count N
// DATA    | receiving payload words, writing imem
// TRL     | receiving 4-byte checksum
// DONE    | load good, core released
// ERR     | oversize header or checksum mismatch, core held
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] words_o
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] n_q, n_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [ADDR_W-1:0] words_q, words_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              accept;
   logic              start_go;
   logic              word_valid;
   logic [31:0]       word;

   assign byte_ready_o = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                         (state_q == ST_TRL);
   assign accept       = byte_valid_i && byte_ready_o;
   assign start_go     = start_i && !byte_ready_o;

   imem_loader_pack u_pack (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (start_go),
      .byte_en_i    (accept),
      .byte_i       (byte_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sum_d   = sum_q;
      words_d = words_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_go) begin
               state_d = ST_HDR;
               n_d     = '0;
               sum_d   = '0;
               words_d = '0;
            end
         end
         ST_HDR: begin
            if (word_valid) begin
               n_d = word;
               if (word > DATA_W'(DEPTH)) state_d = ST_ERR;
               else if (word == '0)       state_d = ST_TRL;
               else                       state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = {words_q[ADDR_W-3:0], 2'b00};
               wdata_d = word;
               sum_d   = sum_q + word;
               words_d = words_q + 1'b1;
               if (words_d == ADDR_W'(n_q)) state_d = ST_TRL;
            end
         end
         ST_TRL: begin
            if (word_valid) state_d = (word == sum_q) ? ST_DONE : ST_ERR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         sum_q   <= '0;
         words_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         sum_q   <= sum_d;
         words_q <= words_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we_o       = we_q;
   assign waddr_o    = waddr_q;
   assign wdata_o    = wdata_q;
   assign words_o    = words_q;
   assign busy_o     = byte_ready_o;
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = (state_q == ST_ERR);
   assign cpu_hold_o = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int DEPTH = 2048;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [7:0]  byte_i = '0;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o, we_o, cpu_hold_o, busy_o, done_o, err_o;
   logic [31:0] waddr_o, wdata_o, words_o;

   imem_loader #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
      .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .we_o(we_o),
      .waddr_o(waddr_o), .wdata_o(wdata_o), .cpu_hold_o(cpu_hold_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // observed imem writes
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   always @(negedge clk_i) begin
      if (we_o) begin
         obs_addr.push_back(waddr_o);
         obs_data.push_back(wdata_o);
      end
   end

   // reference model: parse a byte stream per the frame rules
   logic [7:0]  frm[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_done, exp_err;
   int unsigned exp_words;

   function automatic logic [31:0] le32(input int base);
      return {frm[base+3], frm[base+2], frm[base+1], frm[base]};
   endfunction

   task automatic model();
      int unsigned n;
      logic [31:0] sum;
      exp_addr.delete(); exp_data.delete();
      exp_done = 0; exp_err = 0; exp_words = 0; sum = 0;
      n = le32(0);
      if (n > DEPTH) begin
         exp_err = 1;
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         exp_addr.push_back(32'(i * 4));
         exp_data.push_back(le32(4 + 4 * i));
         sum += le32(4 + 4 * i);
      end
      exp_words = n;
      if (le32(4 + 4 * int'(n)) == sum) exp_done = 1;
      else                              exp_err  = 1;
   endtask

   task automatic push32(input logic [31:0] w);
      for (int i = 0; i < 4; i++) frm.push_back(w[8*i +: 8]);
   endtask

   task automatic build(input int n, input bit good);
      logic [31:0] sum = 0;
      logic [31:0] w;
      frm.delete();
      push32(32'(n));
      for (int i = 0; i < n; i++) begin
         w = $urandom();
         sum += w;
         push32(w);
      end
      push32(good ? sum : sum + 32'($urandom_range(1, 255)));
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // send one byte after gap idle cycles; returns at #1 past the accepting edge
   task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
      int budget;
      for (int g = 0; g < gap; g++) begin
         start_i = mid_start && (g == 0);
         @(posedge clk_i); #1;
         start_i = 1'b0;
      end
      byte_i = b;
      byte_valid_i = 1'b1;
      budget = 200;
      while (!byte_ready_o && budget > 0) begin
         @(posedge clk_i); #1;
         budget--;
      end
      if (budget == 0) chk("accept_timeout", 0, 1);
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int max_gap, input bit mid_start);
      obs_addr.delete(); obs_data.delete();
      model();
      pulse_start();
      foreach (frm[i])
         send_byte(frm[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)),
                   mid_start && (i == 6));
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk({tag, ":nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
      foreach (exp_addr[i]) begin
         if (i < obs_addr.size()) begin
            chk({tag, ":addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
            chk({tag, ":data"}, 64'(obs_data[i]), 64'(exp_data[i]));
         end
      end
      chk({tag, ":done"}, 64'(done_o), 64'(exp_done));
      chk({tag, ":err"}, 64'(err_o), 64'(exp_err));
      chk({tag, ":hold"}, 64'(cpu_hold_o), 64'(!exp_done));
      chk({tag, ":busy"}, 64'(busy_o), 0);
      chk({tag, ":ready"}, 64'(byte_ready_o), 0);
      chk({tag, ":words"}, 64'(words_o), 64'(exp_words));
      @(posedge clk_i); #1;
   endtask

   task automatic good_frame();
      frm.delete();
      push32(32'd2); push32(32'h0000_0013); push32(32'h0010_0093); push32(32'h0010_00A6);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ":hold"}, 64'(cpu_hold_o), 1);
      chk({tag, ":outs"}, 64'({we_o, busy_o, done_o, err_o, byte_ready_o}), 0);
      chk({tag, ":waddr"}, 64'(waddr_o), 0);
      chk({tag, ":wdata"}, 64'(wdata_o), 0);
      chk({tag, ":words"}, 64'(words_o), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      chk_reset_vals("reset");
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      good_frame();
      run_frame("good", 0, 0);

      good_frame();
      frm[15] = 8'hA7;
      run_frame("badsum", 0, 0);

      frm.delete(); push32(32'(DEPTH + 1));
      run_frame("oversize", 0, 0);

      frm.delete(); push32(32'(DEPTH));
      frm.push_back(8'h00);
      model();
      exp_err = 0;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(frm[i], 0, 0);
      chk("depth_ok:busy", 64'(busy_o), 1);
      chk("depth_ok:ready", 64'(byte_ready_o), 1);
      rst_i = 1'b1; #1; rst_i = 1'b0;
      @(posedge clk_i); #1;

      frm.delete(); push32(0); push32(0);
      run_frame("empty", 0, 0);

      good_frame();
      run_frame("gapped", 3, 1);

      // reset after two payload bytes
      obs_addr.delete(); obs_data.delete();
      good_frame();
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(frm[i], 0, 0);
      #2 rst_i = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("midrst:nwr", 64'(obs_addr.size()), 0);
      good_frame();
      run_frame("after_rst", 0, 0);

      for (int t = 0; t < 12; t++) begin
         build(int'($urandom_range(0, 9)), ($urandom_range(0, 3) != 0));
         run_frame($sformatf("rand%0d", t), int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
